// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache address split and controller state.
package cpu_types_pkg;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// Direct-mapped frame storage: one word per set with valid and tag, one
// combinational read port, one write port and a synchronous clear-all.
module icache_frame_array #(
    parameter  int SETS  = 16,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = 30 - IDX_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    // Clear outranks a same-cycle write, so a flushed fill stays invalid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
        end else if (clear) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with single outstanding miss,
// completion-cycle bypass to IF, and hit/miss performance counters.
module icache_direct
    import cpu_types_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic        state_dbg
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    // Handshake: IF holds imemREN/imemaddr until ihit; memory holds iwait high
    // while busy, and iload is taken only in a FETCH cycle with iwait low.

    icache_state_t state_q, state_d;
    logic [29:0]   miss_word_q;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             lookup_hit;

    logic fill_we;
    logic hit_inc;
    logic miss_start;

    logic unused_bits;
    assign unused_bits = &{1'b0, imemaddr[1:0]};

    assign req_idx    = imemaddr[IDX_W+1:2];
    assign req_tag    = imemaddr[31:IDX_W+2];
    assign lookup_hit = imemREN & rd_valid & (rd_tag == req_tag);
    assign state_dbg  = state_q;

    icache_frame_array #(.SETS(SETS)) u_frames (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (flush),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_we),
        .wr_idx   (miss_word_q[IDX_W-1:0]),
        .wr_tag   (miss_word_q[29:IDX_W]),
        .wr_data  (iload)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            miss_word_q <= '0;
        end else begin
            state_q <= state_d;
            if (miss_start) begin
                miss_word_q <= imemaddr[31:2];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        fill_we    = 1'b0;
        hit_inc    = 1'b0;
        miss_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (!flush) begin
                    if (lookup_hit) begin
                        ihit     = 1'b1;
                        imemload = rd_data;
                        hit_inc  = 1'b1;
                    end else if (imemREN) begin
                        miss_start = 1'b1;
                        state_d    = FETCH;
                    end
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {miss_word_q, 2'b00};
                if (flush) begin
                    state_d = IDLE;
                end else if (!iwait) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                    // Bypass only if IF is still asking for the word being filled.
                    if (imemREN && (imemaddr[31:2] == miss_word_q)) begin
                        ihit     = 1'b1;
                        imemload = iload;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_start) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboarded bench for icache_direct: directed scenarios then random
// traffic, checked against a set-indexed cache model in plain arrays.
module tb_icache_direct;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iwait;
    logic [31:0] iload;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic        state_dbg;

    icache_direct #(.SETS(16)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .flush      (flush),
        .iwait      (iwait),
        .iload      (iload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .state_dbg  (state_dbg)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        ihit;
        logic [31:0] load;
        logic        iren;
        logic [31:0] iaddr;
        logic [31:0] hits;
        logic [31:0] misses;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: 16 one-word sets, plus a pending-miss word address.
    bit          m_valid [16];
    logic [25:0] m_tag   [16];
    logic [31:0] m_data  [16];
    bit          m_fetch;
    logic [29:0] m_word;
    logic [31:0] m_hits;
    logic [31:0] m_miss;
    logic [31:0] mem [logic [29:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] w);
        if (mem.exists(w)) return mem[w];
        return {w[15:0], ~w[15:0]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        m_fetch = 0;
        m_word  = '0;
        m_hits  = '0;
        m_miss  = '0;
    endtask

    // One clock cycle of stimulus: drive, predict this cycle's outputs, advance model.
    task automatic step(input bit ren, input logic [31:0] addr, input bit fl, input bit wt);
        exp_t e;
        int unsigned idx;
        logic [25:0] tag;
        @(posedge CLK);
        #1;
        imemREN  = ren;
        imemaddr = addr;
        flush    = fl;
        iwait    = wt;
        iload    = (m_fetch && !wt) ? mem_word(m_word) : $urandom;
        idx = (addr >> 2) % 16;
        tag = addr >> 6;
        e = '0;
        e.hits   = m_hits;
        e.misses = m_miss;
        if (!m_fetch) begin
            if (!fl && ren && m_valid[idx] && m_tag[idx] == tag) begin
                e.ihit = 1'b1;
                e.load = m_data[idx];
                m_hits = m_hits + 1;
            end else if (!fl && ren) begin
                m_miss  = m_miss + 1;
                m_fetch = 1;
                m_word  = addr >> 2;
            end
        end else begin
            e.iren  = 1'b1;
            e.iaddr = {m_word, 2'b00};
            if (fl) begin
                m_fetch = 0;
            end else if (!wt) begin
                m_valid[m_word % 16] = 1;
                m_tag[m_word % 16]   = m_word >> 4;
                m_data[m_word % 16]  = iload;
                if (ren && (addr >> 2) == m_word) begin
                    e.ihit = 1'b1;
                    e.load = iload;
                end
                m_fetch = 0;
            end
        end
        if (fl) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 0;
        end
        exp_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ihit", {31'd0, ihit}, {31'd0, e.ihit});
            if (e.ihit) chk("imemload", imemload, e.load);
            chk("iREN", {31'd0, iREN}, {31'd0, e.iren});
            chk("iaddr", iaddr, e.iaddr);
            chk("hit_count", hit_count, e.hits);
            chk("miss_count", miss_count, e.misses);
        end
    end

    initial begin
        icachef_t a;
        RST = 1'b1; imemREN = 0; imemaddr = '0; flush = 0; iwait = 1; iload = '0;
        model_reset();
        mem[30'h10]  = 32'h8C22_0004;
        mem[30'h110] = 32'h2001_0001;
        repeat (2) @(negedge CLK);
        imemREN = 1; imemaddr = 32'h40;
        #1;
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_iREN", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_miss_count", miss_count, 32'd0);
        imemREN = 0;
        @(negedge CLK);
        RST = 1'b0;

        // Cold miss with three busy cycles, then hit.
        step(1, 32'h40, 0, 1);
        repeat (3) step(1, 32'h40, 0, 1);
        step(1, 32'h40, 0, 0);
        step(1, 32'h40, 0, 1);
        // Conflict on set 0.
        step(1, 32'h440, 0, 1);
        step(1, 32'h440, 0, 0);
        step(1, 32'h40, 0, 1);
        step(1, 32'h40, 0, 0);
        step(0, 32'h0, 0, 1);
        // Flush, then flush colliding with fill completion.
        step(0, 32'h0, 1, 1);
        step(1, 32'h40, 0, 1);
        step(1, 32'h40, 1, 0);
        step(1, 32'h40, 0, 1);
        step(1, 32'h40, 0, 0);
        step(1, 32'h40, 0, 1);
        // Redirect during an outstanding miss.
        step(1, 32'h80, 0, 1);
        step(1, 32'h100, 0, 1);
        step(1, 32'h100, 0, 0);
        step(1, 32'h100, 0, 1);
        step(1, 32'h100, 0, 0);
        step(1, 32'h80, 0, 1);

        // Asynchronous reset while a fill is outstanding.
        step(1, 32'hC0, 0, 1);
        @(posedge CLK);
        #2;
        chk("iREN_before_rst", {31'd0, iREN}, 32'd1);
        RST = 1'b1;
        imemREN = 0;
        #1;
        chk("iREN_in_rst", {31'd0, iREN}, 32'd0);
        chk("iaddr_in_rst", iaddr, 32'd0);
        chk("hit_count_in_rst", hit_count, 32'd0);
        chk("miss_count_in_rst", miss_count, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        step(1, 32'h40, 0, 1);
        step(1, 32'h40, 0, 0);
        step(1, 32'h80, 0, 1);
        step(1, 32'h80, 0, 0);

        // Random traffic over 4 tags x 16 sets.
        for (int n = 0; n < 3000; n++) begin
            a.tag    = 26'($urandom_range(0, 3));
            a.idx    = 4'($urandom_range(0, 15));
            a.bytoff = 2'($urandom_range(0, 3));
            if (m_fetch && $urandom_range(0, 9) < 7) a = {m_word, 2'($urandom_range(0, 3))};
            step($urandom_range(0, 3) != 0, a, $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
        end
        step(0, 32'h0, 0, 1);
        repeat (3) @(negedge CLK);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
